// File: rtl/mcu32x_data_mem_responder.sv
// MCU32X data-bus memory responder: word RAM with configurable wait states and error reporting.
// Optional access counters are enabled with `define MCU32X_MEM_STATS_EN.
module mcu32x_data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        error,
  output logic [1:0]  state_dbg
`ifdef MCU32X_MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);

  // Handshake: the core holds mem_read/mem_write until ready; ready is a single-cycle
  // strobe, error is qualified by ready, rdata is meaningful when ready=1 and error=0.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int          WS_M1_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  WS_M1   = WS_M1_I[3:0];

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [31:0]             mem [2**ADDR_WIDTH];

  logic                    req, req_err;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;
  logic                    wr_q, err_q;

  logic                    commit, mem_we;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [31:0]             op_wdata;
  logic [3:0]              op_be;
  logic                    op_wr, op_err;

  assign req     = mem_read | mem_write;
  assign req_err = (address[1:0] != 2'b00) | (|address[31:ADDR_WIDTH+2]) | (mem_read & mem_write);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: commit fires on the edge that enters RESP; with zero wait states
  // that is the acceptance edge itself, so operands come straight from the bus.
  always_comb begin
    commit   = 1'b0;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_be    = be_q;
    op_wr    = wr_q;
    op_err   = err_q;
    if (state == S_IDLE && req && WAIT_STATES == 0) begin
      commit   = 1'b1;
      op_addr  = address[ADDR_WIDTH+1:2];
      op_wdata = wdata;
      op_be    = byte_en;
      op_wr    = mem_write;
      op_err   = req_err;
    end else if (state == S_WAIT && cnt == 4'd0) begin
      commit = 1'b1;
    end
  end

  assign ready     = (state == S_RESP);
  assign state_dbg = state;
  assign mem_we    = commit & op_wr & ~op_err & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata   <= 32'd0;
      error   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && req) begin
        addr_q  <= address[ADDR_WIDTH+1:2];
        wdata_q <= wdata;
        be_q    <= byte_en;
        wr_q    <= mem_write;
        err_q   <= req_err;
      end
      if (commit) begin
        error <= op_err;
        if (op_err)      rdata <= 32'd0;
        else if (!op_wr) rdata <= mem[op_addr];
      end
    end
  end

  // RAM has no reset so its contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) mem[op_addr][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

`ifdef MCU32X_MEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
      err_count <= 16'd0;
    end else if (commit) begin
      if (op_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (op_wr) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule
